// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: jump flush, load-use bubble and multi-cycle EXE hold with watchdog.
// Latency: all controls decode combinationally from state, counter and current inputs.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_WAIT     = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       exe_valid,
    input  logic       jmp_en,
    input  logic       mdu_start,
    input  logic       mdu_done,
    input  logic       exe_is_load,
    input  logic [4:0] exe_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       stall_idexe,
    output logic       bubble_idexe,
    output logic       clr,
    output logic       mdu_timeout,
    output logic       busy
);

    typedef enum logic [1:0] {RUN, FLUSH, MULTI} state_t;

    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       j, m, lu;

    assign j  = exe_valid & jmp_en;
    assign m  = exe_valid & mdu_start;
    assign lu = exe_valid & exe_is_load & (exe_rd != 5'd0) & id_valid &
                ((id_use_rs1 & (id_rs1 == exe_rd)) | (id_use_rs2 & (id_rs2 == exe_rd)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idexe  = 1'b0;
        bubble_idexe = 1'b0;
        clr          = 1'b0;
        mdu_timeout  = 1'b0;
        busy         = (state != RUN);
        case (state)
            RUN: begin
                if (j) begin
                    clr = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = 8'd1;
                    end
                end else if (m) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idexe = 1'b1;
                    state_nxt   = MULTI;
                    cnt_nxt     = 8'd1;
                end else if (lu) begin
                    stall_pc     = 1'b1;
                    stall_ifid   = 1'b1;
                    bubble_idexe = 1'b1;
                end
            end
            FLUSH: begin
                clr = 1'b1;
                if (j) begin
                    cnt_nxt = 8'd1;
                end else if (cnt == FLUSH_LAST) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            MULTI: begin
                // EXE is frozen here, so jumps and load-use hazards are not live.
                if (mdu_done) begin
                    state_nxt = RUN;
                end else if (cnt == WAIT_LAST) begin
                    mdu_timeout = 1'b1;
                    state_nxt   = RUN;
                end else begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idexe = 1'b1;
                    cnt_nxt     = cnt + 8'd1;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (!rst) begin
            stall_pc     = 1'b0;
            stall_ifid   = 1'b0;
            stall_idexe  = 1'b0;
            bubble_idexe = 1'b0;
            clr          = 1'b0;
            mdu_timeout  = 1'b0;
            busy         = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (default and short watchdog) checked every cycle
// against a countdown-based reference model under directed and random stimulus.
module tb_pipe_ctrl;

    localparam int FC0 = 2;
    localparam int MW0 = 40;
    localparam int FC1 = 2;
    localparam int MW1 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       exe_valid, jmp_en, mdu_start, mdu_done, exe_is_load;
    logic [4:0] exe_rd, id_rs1, id_rs2;
    logic       id_valid, id_use_rs1, id_use_rs2;

    logic       sp0, si0, se0, bb0, cl0, to0, by0;
    logic       sp1, si1, se1, bb1, cl1, to1, by1;
    logic [6:0] obs0, obs1;

    int checks = 0;
    int fails  = 0;

    // model state: remaining flush cycles after this one, remaining watchdog budget
    int flush_rem [2];
    int wait_left [2];
    bit mdu_on    [2];

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(FC0), .MAX_WAIT(MW0)) dut (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .jmp_en(jmp_en),
        .mdu_start(mdu_start), .mdu_done(mdu_done), .exe_is_load(exe_is_load),
        .exe_rd(exe_rd), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .stall_pc(sp0), .stall_ifid(si0), .stall_idexe(se0), .bubble_idexe(bb0),
        .clr(cl0), .mdu_timeout(to0), .busy(by0)
    );

    pipe_ctrl #(.FLUSH_CYCLES(FC1), .MAX_WAIT(MW1)) dut_w (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .jmp_en(jmp_en),
        .mdu_start(mdu_start), .mdu_done(mdu_done), .exe_is_load(exe_is_load),
        .exe_rd(exe_rd), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .stall_pc(sp1), .stall_ifid(si1), .stall_idexe(se1), .bubble_idexe(bb1),
        .clr(cl1), .mdu_timeout(to1), .busy(by1)
    );

    // bit order: stall_pc stall_ifid stall_idexe bubble clr timeout busy
    assign obs0 = {sp0, si0, se0, bb0, cl0, to0, by0};
    assign obs1 = {sp1, si1, se1, bb1, cl1, to1, by1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", tag, got[6:0], exp[6:0]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            flush_rem[i] = 0;
            wait_left[i] = 0;
            mdu_on[i]    = 1'b0;
        end
    endtask

    task automatic model(input int i, input int fc, input int mw, output logic [6:0] o);
        bit jq, mq, luq;
        bit s3, sb, bub, cl, to, by;
        jq  = exe_valid && jmp_en;
        mq  = exe_valid && mdu_start;
        luq = exe_valid && exe_is_load && exe_rd != 0 && id_valid &&
              ((id_use_rs1 && id_rs1 == exe_rd) || (id_use_rs2 && id_rs2 == exe_rd));
        s3 = 0; sb = 0; bub = 0; cl = 0; to = 0;
        by = (flush_rem[i] > 0) || mdu_on[i];
        if (mdu_on[i]) begin
            if (mdu_done) mdu_on[i] = 1'b0;
            else if (wait_left[i] == 1) begin
                to = 1;
                mdu_on[i] = 1'b0;
            end else begin
                s3 = 1;
                wait_left[i]--;
            end
        end else if (flush_rem[i] > 0) begin
            cl = 1;
            flush_rem[i] = jq ? fc - 1 : flush_rem[i] - 1;
        end else if (jq) begin
            cl = 1;
            flush_rem[i] = fc - 1;
        end else if (mq) begin
            s3 = 1;
            mdu_on[i] = 1'b1;
            wait_left[i] = mw;
        end else if (luq) begin
            sb = 1;
            bub = 1;
        end
        o = {s3 | sb, s3 | sb, s3, bub, cl, to, by};
    endtask

    int cyc = 0;

    task automatic step();
        logic [6:0] e0, e1;
        @(negedge clk);
        model(0, FC0, MW0, e0);
        model(1, FC1, MW1, e1);
        check($sformatf("dut c%0d", cyc), 32'(obs0), 32'(e0));
        check($sformatf("dut_w c%0d", cyc), 32'(obs1), 32'(e1));
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit jv, input bit mv, input bit dv, input bit lv,
                         input logic [4:0] rd, input logic [4:0] rs2, input bit u2);
        exe_valid   = 1'b1;
        id_valid    = 1'b1;
        jmp_en      = jv;
        mdu_start   = mv;
        mdu_done    = dv;
        exe_is_load = lv;
        exe_rd      = rd;
        id_rs1      = 5'd0;
        id_rs2      = rs2;
        id_use_rs1  = 1'b0;
        id_use_rs2  = u2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 0, 0, 5'd0, 5'd0, 0);
            step();
        end
    endtask

    initial begin
        rst = 1'b0;
        exe_valid = 1; jmp_en = 1; mdu_start = 1; mdu_done = 1; exe_is_load = 1;
        exe_rd = 5'd31; id_valid = 1; id_rs1 = 5'd31; id_rs2 = 5'd31;
        id_use_rs1 = 1; id_use_rs2 = 1;
        model_reset();
        #2;
        check("reset dut", 32'(obs0), 32'd0);
        check("reset dut_w", 32'(obs1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        drive(1, 0, 0, 0, 5'd0, 5'd0, 0); step();     // single jump
        idle(2);
        drive(1, 0, 0, 0, 5'd0, 5'd0, 0); step();     // jump extended inside flush
        drive(1, 0, 0, 0, 5'd0, 5'd0, 0); step();
        idle(2);
        drive(0, 0, 0, 1, 5'd5, 5'd5, 1); step();     // load-use hazard
        idle(1);
        drive(0, 0, 0, 1, 5'd0, 5'd0, 1); step();     // x0 never hazards
        idle(1);
        drive(1, 0, 0, 1, 5'd5, 5'd5, 1); step();     // jump beats load-use
        idle(2);
        drive(0, 1, 0, 0, 5'd0, 5'd0, 0); step();     // mdu, done at cycle 5
        idle(4);
        drive(0, 0, 1, 0, 5'd0, 5'd0, 0); step();
        idle(2);
        drive(0, 1, 0, 0, 5'd0, 5'd0, 0); step();     // watchdog on short instance
        idle(3);
        drive(0, 0, 1, 0, 5'd0, 5'd0, 0); step();
        idle(2);
        drive(0, 1, 0, 0, 5'd0, 5'd0, 0); step();     // done races timeout
        idle(2);
        drive(0, 0, 1, 0, 5'd0, 5'd0, 0); step();
        idle(2);

        drive(0, 1, 0, 0, 5'd0, 5'd0, 0); step();     // reset in the middle of MULTI
        idle(1);
        rst = 1'b0;
        #1;
        check("midreset dut", 32'(obs0), 32'd0);
        check("midreset dut_w", 32'(obs1), 32'd0);
        model_reset();
        #1;
        rst = 1'b1;
        drive(0, 1, 0, 0, 5'd0, 5'd0, 0); step();
        idle(4);
        drive(0, 0, 1, 0, 5'd0, 5'd0, 0); step();
        idle(1);

        for (int n = 0; n < 3000; n++) begin
            exe_valid   = ($urandom_range(0, 9) < 8);
            jmp_en      = ($urandom_range(0, 9) == 0);
            mdu_start   = ($urandom_range(0, 19) < 3);
            mdu_done    = ($urandom_range(0, 19) < 3);
            exe_is_load = ($urandom_range(0, 9) < 3);
            exe_rd      = 5'($urandom_range(0, 3));
            id_valid    = ($urandom_range(0, 9) < 9);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
